// File: rtl/dw_ctrl_pkg.sv
// Shared encodings for the depthwise-conv row-buffer sequencer.
package dw_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_e;

  localparam logic STRIDE1 = 1'b0;
  localparam logic STRIDE2 = 1'b1;
  localparam int   MIN_DIM = 3;

endpackage

// File: rtl/dw_pos_counter.sv
// Column/row position of the incoming pixel stream, with a last-pixel flag.
module dw_pos_counter #(
  parameter int DEPTH = 9,
  parameter int ROW_W = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             inc,
  input  logic [DEPTH-1:0] width,
  input  logic [ROW_W-1:0] height,
  output logic [DEPTH-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic col_end;

  assign col_end = (col == width - DEPTH'(1));
  assign last    = col_end && (row == height - ROW_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + DEPTH'(1);
      end
    end
  end

endmodule

// File: rtl/dw_row_buff_ctrl.sv
// Sequencer for the DW 3-row line buffer: config latch, pixel gating,
// position tracking and 3x3 window qualification.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; abort blocks any transfer in its cycle.
module dw_row_buff_ctrl
  import dw_ctrl_pkg::*;
#(
  parameter int DEPTH   = 9,
  parameter int ROW_W   = 9,
  parameter int MAX_LEN = 318
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DEPTH-1:0] cfg_width,
  input  logic [ROW_W-1:0] cfg_height,
  input  logic             cfg_stride,
  output logic             cfg_err,
  input  logic             abort,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             buff_valid_in,
  output logic [DEPTH-1:0] buff_len_ctrl,
  output logic             buff_len_rst,
  output logic             win_valid,
  output logic [DEPTH-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done,
  output logic             busy,
  output ctrl_state_e      state
);

  ctrl_state_e      state_q, state_d;
  logic [ROW_W-1:0] height_q;
  logic             stride_q;
  logic             cfg_legal, cfg_hs, accept, qualify;
  logic [DEPTH-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_pix;

  assign cfg_legal = (cfg_width >= DEPTH'(MIN_DIM)) && (cfg_width <= DEPTH'(MAX_LEN)) &&
                     (cfg_height >= ROW_W'(MIN_DIM));

  assign cfg_ready     = (state_q == IDLE);
  assign pix_ready     = (state_q == RUN);
  assign buff_len_rst  = (state_q == LOAD);
  assign frame_done    = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign state         = state_q;
  assign cfg_hs        = cfg_valid && cfg_ready && !abort;
  assign buff_valid_in = pix_valid && pix_ready;
  // An aborted pixel still reaches the buffer, but LOAD re-zeroes it anyway.
  assign accept        = buff_valid_in && !abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_hs && cfg_legal) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (accept && last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buff_len_ctrl <= DEPTH'(MAX_LEN);
      height_q      <= '0;
      stride_q      <= STRIDE1;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= cfg_hs && !cfg_legal;
      if (cfg_hs && cfg_legal) begin
        buff_len_ctrl <= cfg_width;
        height_q      <= cfg_height;
        stride_q      <= cfg_stride;
      end
    end
  end

  dw_pos_counter #(
    .DEPTH (DEPTH),
    .ROW_W (ROW_W)
  ) u_pos (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (buff_len_rst || abort),
    .inc    (accept),
    .width  (buff_len_ctrl),
    .height (height_q),
    .col    (col),
    .row    (row),
    .last   (last_pix)
  );

  // With stride 2, (col-2) and (row-2) even is the same as bit 0 clear.
  assign qualify = accept && (col >= DEPTH'(2)) && (row >= ROW_W'(2)) &&
                   ((stride_q == STRIDE1) || (!col[0] && !row[0]));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      win_valid <= qualify;
      if (qualify) begin
        win_col <= col;
        win_row <= row;
      end
    end
  end

endmodule

// File: tb/tb_dw_row_buff_ctrl.sv
// Self-checking bench for dw_row_buff_ctrl: scoreboard of expected windows
// plus per-scenario checks of handshakes, pulses and reset behaviour.
module tb_dw_row_buff_ctrl;
  import dw_ctrl_pkg::*;

  localparam int DEPTH   = 9;
  localparam int ROW_W   = 9;
  localparam int MAX_LEN = 318;
  localparam int W       = DEPTH + ROW_W;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cfg_valid, cfg_ready, cfg_stride, cfg_err;
  logic [DEPTH-1:0] cfg_width;
  logic [ROW_W-1:0] cfg_height;
  logic             abort, pix_valid, pix_ready, buff_valid_in;
  logic [DEPTH-1:0] buff_len_ctrl;
  logic             buff_len_rst, win_valid, frame_done, busy;
  logic [DEPTH-1:0] win_col;
  logic [ROW_W-1:0] win_row;
  ctrl_state_e      state;

  dw_row_buff_ctrl #(.DEPTH(DEPTH), .ROW_W(ROW_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .cfg_err(cfg_err), .abort(abort), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .buff_valid_in(buff_valid_in), .buff_len_ctrl(buff_len_ctrl),
    .buff_len_rst(buff_len_rst), .win_valid(win_valid), .win_col(win_col),
    .win_row(win_row), .frame_done(frame_done), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int win_cnt, acc_cnt, done_cnt, err_cnt, lrst_cnt;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (win_valid) begin
        win_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL win_unexpected: got row %0d col %0d, required no window", win_row, win_col);
        end else begin
          exp_w = exp_q.pop_front();
          if ({win_row, win_col} !== exp_w) begin
            errors++;
            $display("FAIL win_pos: got row %0d col %0d, required row %0d col %0d",
                     win_row, win_col, exp_w[W-1:DEPTH], exp_w[DEPTH-1:0]);
          end
        end
      end
      if (buff_valid_in) acc_cnt++;
      if (frame_done)    done_cnt++;
      if (cfg_err)       err_cnt++;
      if (buff_len_rst)  lrst_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    win_cnt = 0; acc_cnt = 0; done_cnt = 0; err_cnt = 0; lrst_cnt = 0;
  endtask

  task automatic send_cfg(input int w, input int h, input int s);
    cfg_valid  = 1'b1;
    cfg_width  = DEPTH'(w);
    cfg_height = ROW_W'(h);
    cfg_stride = s[0];
    step();
    cfg_valid  = 1'b0;
  endtask

  // Independent reference for which pixel positions close a 3x3 window.
  task automatic model_pixel(input int n, input int w, input int s);
    int c, r;
    c = n % w;
    r = n / w;
    if (r >= 2 && c >= 2 && (s == 0 || (((r - 2) % 2 == 0) && ((c - 2) % 2 == 0))))
      exp_q.push_back({ROW_W'(r), DEPTH'(c)});
  endtask

  task automatic run_frame(input int w, input int h, input int s, input int gap,
                           input int exp_win, input string name);
    int n;
    clear_counts();
    send_cfg(w, h, s);
    checks++;
    if (buff_len_rst !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_load: got len_rst %b pix_ready %b, required 1 0", name, buff_len_rst, pix_ready);
    end
    checks++;
    if (buff_len_ctrl !== DEPTH'(w)) begin
      errors++;
      $display("FAIL %s_len: got %0d, required %0d", name, buff_len_ctrl, w);
    end
    step();
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_run: got pix_ready %b, required 1", name, pix_ready);
    end
    n = 0;
    while (n < w * h) begin
      pix_valid = ($urandom_range(0, 99) >= gap);
      if (pix_valid) begin
        model_pixel(n, w, s);
        n++;
      end
      step();
    end
    pix_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got frame_done %b pix_ready %b, required 1 0", name, frame_done, pix_ready);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got cfg_ready %b frame_done %b busy %b, required 1 0 0",
               name, cfg_ready, frame_done, busy);
    end
    step();
    checks++;
    if (acc_cnt != w * h || done_cnt != 1 || lrst_cnt != 1) begin
      errors++;
      $display("FAIL %s_counts: got accepts %0d done %0d len_rst %0d, required %0d 1 1",
               name, acc_cnt, done_cnt, lrst_cnt, w * h);
    end
    checks++;
    if (win_cnt != exp_win || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_wins: got %0d windows (%0d pending), required %0d (0 pending)",
               name, win_cnt, exp_q.size(), exp_win);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (cfg_ready !== 1'b1 || pix_ready !== 1'b0 || buff_len_rst !== 1'b0 ||
        win_valid !== 1'b0 || frame_done !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: got rdy %b prdy %b lrst %b wv %b fd %b err %b busy %b, required 1 0 0 0 0 0 0",
               name, cfg_ready, pix_ready, buff_len_rst, win_valid, frame_done, cfg_err, busy);
    end
    checks++;
    if (buff_len_ctrl !== DEPTH'(MAX_LEN) || win_col !== '0 || win_row !== '0 || state !== IDLE) begin
      errors++;
      $display("FAIL %s_regs: got len %0d col %0d row %0d state %0d, required %0d 0 0 0",
               name, buff_len_ctrl, win_col, win_row, state, MAX_LEN);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_valid = 1'b0; cfg_width = '0; cfg_height = '0; cfg_stride = 1'b0;
    abort = 1'b0; pix_valid = 1'b0;
    #23;
    check_reset_values("reset");
    rstn = 1'b1;
    step();
    check_reset_values("reset_release");
  endtask

  task automatic test_illegal(input int w, input int h, input int exp_len, input string name);
    clear_counts();
    send_cfg(w, h, 0);
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || buff_len_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s_err: got cfg_err %b busy %b len_rst %b, required 1 0 0", name, cfg_err, busy, buff_len_rst);
    end
    step();
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || lrst_cnt != 0 || buff_len_ctrl !== DEPTH'(exp_len)) begin
      errors++;
      $display("FAIL %s_after: got cfg_err %b busy %b len_rst_cnt %0d len %0d, required 0 0 0 %0d",
               name, cfg_err, busy, lrst_cnt, buff_len_ctrl, exp_len);
    end
  endtask

  task automatic test_abort();
    clear_counts();
    send_cfg(5, 4, 0);
    step();
    for (int n = 0; n < 13; n++) begin
      pix_valid = 1'b1;
      model_pixel(n, 5, 0);
      step();
    end
    pix_valid = 1'b1;
    abort     = 1'b1;
    step();
    abort     = 1'b0;
    pix_valid = 1'b0;
    checks++;
    if (state !== IDLE || busy !== 1'b0 || pix_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got state %0d busy %b pix_ready %b cfg_ready %b, required 0 0 0 1",
               state, busy, pix_ready, cfg_ready);
    end
    repeat (3) step();
    checks++;
    if (done_cnt != 0 || win_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_counts: got done %0d windows %0d pending %0d, required 0 1 0",
               done_cnt, win_cnt, exp_q.size());
    end
    run_frame(5, 4, 0, 0, 6, "abort_next");
  endtask

  task automatic test_async_reset();
    clear_counts();
    send_cfg(6, 3, 0);
    step();
    for (int n = 0; n < 16; n++) begin
      pix_valid = 1'b1;
      model_pixel(n, 6, 0);
      step();
    end
    pix_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    #10;
    rstn = 1'b1;
    step();
    checks++;
    if (cfg_ready !== 1'b1 || state !== IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got cfg_ready %b state %0d busy %b, required 1 0 0", cfg_ready, state, busy);
    end
    run_frame(6, 3, 0, 0, 4, "after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    run_frame(5, 4, 0, 0, 6, "stride1");
    run_frame(7, 5, 1, 0, 6, "stride2");
    test_illegal(2, 4, 7, "width2");
    test_illegal(5, 2, 7, "height2");
    test_illegal(319, 4, 7, "width319");
    run_frame(6, 3, 0, 50, 4, "gaps");
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dw_row_buff_ctrl.md
# dw_row_buff_ctrl

Sequencer for the depthwise-conv 3-row line buffer in the DW pre-process path. It accepts a per-frame configuration (width, height, stride) and programs the row buffer's length. It then gates the pixel stream into the buffer, tracks the column/row position, and flags cycles where the buffer output holds a complete 3×3 window. It sits between the feature-map fetch logic (upstream) and the row buffer plus DW MAC array (downstream).

## Interface
Parameters:
- DEPTH, 9, row-buffer address width; also the width of cfg_width and buff_len_ctrl.
- ROW_W, 9, width of the row counter and cfg_height.
- MAX_LEN, 318, largest legal cfg_width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: asynchronous, active-low.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high only in IDLE.
- cfg_width  in  DEPTH  pixels per row.
- cfg_height  in  ROW_W  rows per frame.
- cfg_stride  in  1  window stride: 0 = stride 1, 1 = stride 2.
- cfg_err  out  1  one-cycle pulse when an offered configuration is rejected.
- abort  in  1  synchronous frame abort.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  high only in RUN.
- buff_valid_in  out  1  combinational pix_valid & pix_ready; drives the row buffer's valid_in.
- buff_len_ctrl  out  DEPTH  latched cfg_width.
- buff_len_rst  out  1  one-cycle pulse in LOAD.
- win_valid  out  1  row-buffer data_out holds a window to be computed.
- win_col  out  DEPTH  column of the window's bottom-right pixel.
- win_row  out  ROW_W  row of the window's bottom-right pixel.
- frame_done  out  1  one-cycle pulse after the final pixel.
- busy  out  1  state != IDLE.

## Operation
States and transitions:
- IDLE → LOAD on a cfg handshake with a legal config.
- LOAD → RUN unconditionally.
- RUN → DONE when the last pixel is accepted.
- DONE → IDLE unconditionally.
- abort forces IDLE from any state, including LOAD and DONE. It takes priority over every other event in the same cycle.

Configuration:
- Legal config: 3 ≤ cfg_width ≤ MAX_LEN and cfg_height ≥ 3.
- Illegal config: pulse cfg_err on the cycle after the handshake, stay in IDLE, latch nothing.
- Width, height and stride are latched on the handshake and are stable until the next accepted config.

Position counters (col, row):
- Both cleared in LOAD.
- Each accepted pixel increments col.
- col == width−1 wraps col to 0 and increments row.
- Counters hold while pix_valid is low.

Window qualification, evaluated on the accepted pixel at (col, row):
- Requires row ≥ 2 and col ≥ 2.
- When cfg_stride = 1, additionally requires (row−2) even and (col−2) even.
- Qualified pixel: win_valid pulses with win_col/win_row = that pixel's position.
- Unqualified cycles: win_col/win_row hold their previous values.

Frame end:
- The last pixel is (width−1, height−1). Its acceptance moves the FSM to DONE.
- frame_done is high for exactly the DONE cycle.
- Pixels offered after the last pixel are not accepted because pix_ready is low.

Abort:
- Clears the counters.
- No frame_done is issued.
- The next frame requires a new cfg handshake and LOAD.
- Since buff_len_rst re-zeroes the buffer pointers in the next LOAD, no explicit flush is needed.

## Timing
Reset values:
- cfg_ready = 1.
- pix_ready, buff_len_rst, win_valid, frame_done, cfg_err, busy = 0.
- buff_len_ctrl = MAX_LEN; win_col, win_row = 0; state = IDLE.

Latencies:
- cfg handshake at cycle T → buff_len_rst = 1 at T+1 → pix_ready = 1 from T+2.
- win_valid is registered, one cycle after the qualifying pixel's acceptance. This matches the row buffer's 1-cycle read latency.
- Last pixel accepted at L → frame_done = 1 and the last win_valid at L+1 → cfg_ready = 1 at L+2.

Other rules:
- buff_valid_in has zero latency and is never high outside RUN.
- cfg_valid held high across a busy frame is accepted only at the first IDLE cycle.

## Structure
- Package dw_ctrl_pkg holds:
  - FSM state encoding: IDLE = 0, LOAD = 1, RUN = 2, DONE = 3.
  - Stride encoding constants STRIDE1 = 0 and STRIDE2 = 1.
  - Minimum legal dimension constant MIN_DIM = 3.
- Sub-module dw_pos_counter holds the col/row counters with their clear, increment, wrap and last-pixel flag. The FSM and window-qualification logic stay in the top.

## Test plan
- W=5, H=4, stride 1, pix_valid continuously high:
  - 20 pixels accepted; 6 win_valid at (2,2), (3,2), (4,2), (2,3), (3,3), (4,3).
  - frame_done exactly once, one cycle after pixel 20.
- W=7, H=5, stride 2:
  - 6 win_valid at cols {2,4,6} × rows {2,4}; no win_valid on odd offsets.
- cfg_width=2, then cfg_height=2, then cfg_width=319:
  - cfg_err pulses each time; busy stays 0; buff_len_rst never asserts.
- Random pix_valid gaps (50 %), W=6, H=3:
  - Counters hold during gaps; 4 win_valid total.
  - buff_valid_in equals the accept count (18).
- abort asserted mid-RUN at row 2, col 3, in the same cycle as a pix_valid:
  - Pixel not counted; IDLE next cycle; no frame_done.
  - A following frame starts from (0,0) after a fresh buff_len_rst.
- rstn dropped mid-RUN:
  - All outputs return to their reset values immediately (asynchronously).
  - cfg_ready = 1 on the first clock after release.
